// File: rtl/io_bus_bridge.sv
// CPU byte-bus bridge: splits accesses between 128 KB RAM and the I/O page, owns the UART FIFOs,
// the cycle counter and the stop flag; read data comes back one cycle after the address.

module io_bus_bridge_fifo #(
   parameter int DEPTH_LOG = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_push,
   input  logic [7:0]           i_push_dat,
   input  logic                 i_pop,
   output logic [7:0]           o_head,
   output logic                 o_empty,
   output logic                 o_full,
   output logic [DEPTH_LOG:0]   o_count
);
   localparam int DEPTH = 1 << DEPTH_LOG;

   logic [7:0]         r_mem [0:DEPTH-1];
   logic [DEPTH_LOG:0] r_wp;
   logic [DEPTH_LOG:0] r_rp;

   // Caller only asserts i_push/i_pop when they are legal for the current fill level.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wp <= '0;
         r_rp <= '0;
      end else begin
         if (i_push) r_wp <= r_wp + (DEPTH_LOG+1)'(1);
         if (i_pop)  r_rp <= r_rp + (DEPTH_LOG+1)'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_push) r_mem[r_wp[DEPTH_LOG-1:0]] <= i_push_dat;
   end

   assign o_head  = r_mem[r_rp[DEPTH_LOG-1:0]];
   assign o_empty = (r_wp == r_rp);
   assign o_full  = (r_wp[DEPTH_LOG] != r_rp[DEPTH_LOG]) &&
                    (r_wp[DEPTH_LOG-1:0] == r_rp[DEPTH_LOG-1:0]);
   assign o_count = r_wp - r_rp;
endmodule

module io_bus_bridge #(
   parameter int TX_DEPTH_LOG = 4,
   parameter int RX_DEPTH_LOG = 4,
   parameter int FULL_MARGIN  = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic [31:0] cpu_a,
   input  logic [7:0]  cpu_dout,
   input  logic        cpu_wr,
   output logic [7:0]  cpu_din,
   output logic        io_buffer_full,
   output logic [16:0] ram_a,
   output logic [7:0]  ram_dout,
   output logic        ram_we,
   input  logic [7:0]  ram_din,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        prog_stop,
   output logic        rx_overflow
);
   localparam logic [TX_DEPTH_LOG:0] TX_DEPTH_V  = (TX_DEPTH_LOG+1)'(1 << TX_DEPTH_LOG);
   localparam logic [TX_DEPTH_LOG:0] TX_MARGIN_V = (TX_DEPTH_LOG+1)'(FULL_MARGIN);

   logic                    w_io;
   logic [2:0]              w_off;
   logic                    w_io_rd;
   logic                    w_io_wr;
   logic                    w_rx_pop_req;
   logic                    w_snap;
   logic                    w_tx_push_req;
   logic [7:0]              w_tx_push_dat;

   logic                    w_tx_push;
   logic                    w_tx_pop;
   logic [7:0]              w_tx_head;
   logic                    w_tx_empty;
   logic                    w_tx_full;
   logic [TX_DEPTH_LOG:0]   w_tx_count;
   logic [TX_DEPTH_LOG:0]   w_tx_free;

   logic                    w_rx_push;
   logic                    w_rx_pop;
   logic [7:0]              w_rx_head;
   logic                    w_rx_empty;
   logic                    w_rx_full;
   logic [RX_DEPTH_LOG:0]   w_rx_count;

   logic [7:0]              w_din_mux;
   logic                    w_unused;

   logic                    r_sel_io;
   logic [2:0]              r_sel_off;
   logic                    r_rdy_q;
   logic [7:0]              r_din_hold;
   logic [7:0]              r_rx_byte;
   logic [31:0]             r_cnt;
   logic [31:0]             r_cnt_snap;
   logic                    r_stop;
   logic                    r_rx_ovf;

   assign w_io    = (cpu_a[17:16] == 2'b11);
   assign w_off   = cpu_a[2:0];
   assign w_io_rd = rdy_in & w_io & ~cpu_wr;
   assign w_io_wr = rdy_in & w_io & cpu_wr;

   assign ram_a    = cpu_a[16:0];
   assign ram_dout = cpu_dout;
   assign ram_we   = cpu_wr & ~w_io & rdy_in;

   assign w_rx_pop_req  = w_io_rd & (w_off == 3'd0);
   assign w_snap        = w_io_rd & (w_off == 3'd4);
   // A stop write also queues a NUL so the host sees the end of output.
   assign w_tx_push_req = w_io_wr & (((w_off == 3'd0) && (cpu_dout != 8'h00)) || (w_off == 3'd4));
   assign w_tx_push_dat = (w_off == 3'd4) ? 8'h00 : cpu_dout;

   assign w_tx_push = w_tx_push_req & ~w_tx_full;
   assign w_tx_pop  = ~w_tx_empty & tx_ready;

   io_bus_bridge_fifo #(.DEPTH_LOG(TX_DEPTH_LOG)) u_tx_fifo (
      .i_clk      (clk_in),
      .i_rst      (rst_in),
      .i_push     (w_tx_push),
      .i_push_dat (w_tx_push_dat),
      .i_pop      (w_tx_pop),
      .o_head     (w_tx_head),
      .o_empty    (w_tx_empty),
      .o_full     (w_tx_full),
      .o_count    (w_tx_count)
   );

   assign w_tx_free      = TX_DEPTH_V - w_tx_count;
   assign io_buffer_full = (w_tx_free <= TX_MARGIN_V);
   assign tx_valid       = ~w_tx_empty;
   assign tx_data        = w_tx_head;

   // A full RX FIFO still accepts a byte when the cpu pops in the same cycle.
   assign w_rx_pop  = w_rx_pop_req & ~w_rx_empty;
   assign w_rx_push = rx_valid & (~w_rx_full | w_rx_pop);

   io_bus_bridge_fifo #(.DEPTH_LOG(RX_DEPTH_LOG)) u_rx_fifo (
      .i_clk      (clk_in),
      .i_rst      (rst_in),
      .i_push     (w_rx_push),
      .i_push_dat (rx_data),
      .i_pop      (w_rx_pop),
      .o_head     (w_rx_head),
      .o_empty    (w_rx_empty),
      .o_full     (w_rx_full),
      .o_count    (w_rx_count)
   );

   assign w_unused = ^{cpu_a[31:18], w_rx_count};

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_sel_io   <= 1'b0;
         r_sel_off  <= 3'd0;
         r_rdy_q    <= 1'b0;
         r_din_hold <= 8'h00;
         r_rx_byte  <= 8'h00;
         r_cnt      <= 32'd0;
         r_cnt_snap <= 32'd0;
         r_stop     <= 1'b0;
         r_rx_ovf   <= 1'b0;
      end else begin
         r_rdy_q    <= rdy_in;
         r_din_hold <= cpu_din;
         if (rdy_in) begin
            r_sel_io  <= w_io & ~cpu_wr;
            r_sel_off <= w_off;
            r_cnt     <= r_cnt + 32'd1;
         end
         if (w_rx_pop_req) r_rx_byte <= w_rx_empty ? 8'h00 : w_rx_head;
         // Snapshot on the low-byte read keeps the upper bytes coherent.
         if (w_snap) r_cnt_snap <= r_cnt;
         if (w_io_wr && (w_off == 3'd4)) r_stop <= 1'b1;
         if (rx_valid && w_rx_full && !w_rx_pop) r_rx_ovf <= 1'b1;
      end
   end

   always_comb begin
      w_din_mux = 8'h00;
      if (!r_sel_io) begin
         w_din_mux = ram_din;
      end else begin
         case (r_sel_off)
            3'd0:    w_din_mux = r_rx_byte;
            3'd4:    w_din_mux = r_cnt_snap[7:0];
            3'd5:    w_din_mux = r_cnt_snap[15:8];
            3'd6:    w_din_mux = r_cnt_snap[23:16];
            3'd7:    w_din_mux = r_cnt_snap[31:24];
            default: w_din_mux = 8'h00;
         endcase
      end
   end

   // If the previous cycle was stalled, ram_din no longer belongs to the pending read.
   assign cpu_din     = r_rdy_q ? w_din_mux : r_din_hold;
   assign prog_stop   = r_stop;
   assign rx_overflow = r_rx_ovf;
endmodule

// File: tb/tb_io_bus_bridge.sv
// Directed bench for io_bus_bridge with a one-cycle-latency RAM model.

module tb_io_bus_bridge;
   logic        clk_in;
   logic        rst_in;
   logic        rdy_in;
   logic [31:0] cpu_a;
   logic [7:0]  cpu_dout;
   logic        cpu_wr;
   logic [7:0]  cpu_din;
   logic        io_buffer_full;
   logic [16:0] ram_a;
   logic [7:0]  ram_dout;
   logic        ram_we;
   logic [7:0]  ram_din;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        prog_stop;
   logic        rx_overflow;

   int n_tests = 0;
   int n_fail  = 0;
   int ram_we_cnt = 0;
   int we_base;

   logic [7:0] ram_mem [0:131071];

   io_bus_bridge dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .rdy_in         (rdy_in),
      .cpu_a          (cpu_a),
      .cpu_dout       (cpu_dout),
      .cpu_wr         (cpu_wr),
      .cpu_din        (cpu_din),
      .io_buffer_full (io_buffer_full),
      .ram_a          (ram_a),
      .ram_dout       (ram_dout),
      .ram_we         (ram_we),
      .ram_din        (ram_din),
      .rx_valid       (rx_valid),
      .rx_data        (rx_data),
      .tx_valid       (tx_valid),
      .tx_data        (tx_data),
      .tx_ready       (tx_ready),
      .prog_stop      (prog_stop),
      .rx_overflow    (rx_overflow)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) begin
      if (ram_we) begin
         ram_mem[ram_a] <= ram_dout;
         ram_we_cnt <= ram_we_cnt + 1;
      end
      ram_din <= ram_mem[ram_a];
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_in   = 1'b1;
      rdy_in   = 1'b1;
      cpu_a    = 32'h0;
      cpu_dout = 8'h00;
      cpu_wr   = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      tx_ready = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_cpu_din", {24'h0, cpu_din}, 32'h00);
      chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
      chk("rst_prog_stop", {31'h0, prog_stop}, 32'h0);
      chk("rst_rx_overflow", {31'h0, rx_overflow}, 32'h0);
      chk("rst_io_full", {31'h0, io_buffer_full}, 32'h0);
      rst_in = 1'b0;

      // Counter: 20 cycles, rdy low for 5 of them, then read the word
      for (int c = 0; c < 20; c++) begin
         rdy_in = !(c >= 3 && c < 8);
         if (c == 4) begin
            cpu_a = 32'h10; cpu_wr = 1'b1; cpu_dout = 8'h5A;
            #1;
            chk("ram_we_while_stalled", {31'h0, ram_we}, 32'h0);
         end
         tick();
         cpu_a = 32'h0; cpu_wr = 1'b0;
      end
      rdy_in = 1'b1;
      for (int b = 0; b < 4; b++) begin
         cpu_a = 32'h30004 + b;
         tick();
         chk($sformatf("cnt15_byte%0d", b), {24'h0, cpu_din}, (b == 0) ? 32'h0F : 32'h00);
      end
      cpu_a = 32'h0;

      // RAM write then read
      we_base = ram_we_cnt;
      cpu_a = 32'h10; cpu_wr = 1'b1; cpu_dout = 8'hA5;
      #1;
      chk("ram_we_on_write", {31'h0, ram_we}, 32'h1);
      chk("ram_a_on_write", {15'h0, ram_a}, 32'h10);
      tick();
      cpu_wr = 1'b0;
      #1;
      chk("ram_we_on_read", {31'h0, ram_we}, 32'h0);
      tick();
      chk("ram_read_a5", {24'h0, cpu_din}, 32'hA5);
      chk("ram_we_pulses", ram_we_cnt - we_base, 32'd1);
      rdy_in = 1'b0; cpu_a = 32'h20;
      tick();
      chk("cpu_din_hold_stalled", {24'h0, cpu_din}, 32'hA5);
      rdy_in = 1'b1; cpu_a = 32'h0;
      tick();

      // TX: 'H', 'i', 0x00 with the UART always ready
      tx_ready = 1'b1;
      cpu_a = 32'h30000; cpu_wr = 1'b1; cpu_dout = 8'h48;
      tick();
      chk("tx_h_valid", {31'h0, tx_valid}, 32'h1);
      chk("tx_h_data", {24'h0, tx_data}, 32'h48);
      cpu_dout = 8'h69;
      tick();
      chk("tx_i_valid", {31'h0, tx_valid}, 32'h1);
      chk("tx_i_data", {24'h0, tx_data}, 32'h69);
      cpu_dout = 8'h00;
      tick();
      chk("tx_nul_dropped", {31'h0, tx_valid}, 32'h0);
      cpu_wr = 1'b0; cpu_a = 32'h0;
      tick();
      chk("tx_idle", {31'h0, tx_valid}, 32'h0);

      // Backpressure: 17 writes into a 16-deep FIFO
      tx_ready = 1'b0;
      cpu_a = 32'h30000; cpu_wr = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         cpu_dout = 8'(i);
         tick();
         if (i == 13) chk("io_full_after_13", {31'h0, io_buffer_full}, 32'h0);
         if (i == 14) chk("io_full_after_14", {31'h0, io_buffer_full}, 32'h1);
      end
      cpu_wr = 1'b0; cpu_a = 32'h0;
      tx_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("drain_valid_%0d", k), {31'h0, tx_valid}, 32'h1);
         chk($sformatf("drain_data_%0d", k), {24'h0, tx_data}, 32'(k + 1));
         tick();
      end
      chk("drain_empty", {31'h0, tx_valid}, 32'h0);
      chk("drain_io_full", {31'h0, io_buffer_full}, 32'h0);

      // RX: two bytes, three reads
      rx_valid = 1'b1; rx_data = 8'h31;
      tick();
      rx_data = 8'h32;
      tick();
      rx_valid = 1'b0;
      cpu_a = 32'h30000;
      tick();
      chk("rx_rd0", {24'h0, cpu_din}, 32'h31);
      tick();
      chk("rx_rd1", {24'h0, cpu_din}, 32'h32);
      tick();
      chk("rx_rd_empty", {24'h0, cpu_din}, 32'h00);
      cpu_a = 32'h0;
      tick();
      chk("rx_no_overflow", {31'h0, rx_overflow}, 32'h0);

      // RX overflow, then a push/pop on a full FIFO
      rx_valid = 1'b1;
      for (int i = 0; i < 17; i++) begin
         rx_data = 8'h40 + 8'(i);
         tick();
         if (i == 15) chk("rx_ovf_at_16", {31'h0, rx_overflow}, 32'h0);
         if (i == 16) chk("rx_ovf_at_17", {31'h0, rx_overflow}, 32'h1);
      end
      rx_data = 8'h99;
      cpu_a = 32'h30000;
      tick();
      chk("rx_full_pushpop", {24'h0, cpu_din}, 32'h40);
      rx_valid = 1'b0;
      for (int k = 1; k < 16; k++) begin
         tick();
         chk($sformatf("rx_rd_%0d", k), {24'h0, cpu_din}, 32'h40 + 32'(k));
      end
      tick();
      chk("rx_rd_pushed_on_full", {24'h0, cpu_din}, 32'h99);
      tick();
      chk("rx_rd_after_drain", {24'h0, cpu_din}, 32'h00);
      cpu_a = 32'h0;

      // Stop flag, then reset with 3 bytes queued
      tx_ready = 1'b0;
      cpu_a = 32'h30004; cpu_wr = 1'b1; cpu_dout = 8'h77;
      tick();
      chk("stop_set", {31'h0, prog_stop}, 32'h1);
      chk("stop_tx_valid", {31'h0, tx_valid}, 32'h1);
      chk("stop_tx_nul", {24'h0, tx_data}, 32'h00);
      cpu_a = 32'h30000; cpu_dout = 8'h41;
      tick();
      cpu_dout = 8'h42;
      tick();
      chk("stop_sticky", {31'h0, prog_stop}, 32'h1);
      cpu_wr = 1'b0; cpu_a = 32'h0;
      rst_in = 1'b1;
      tick();
      chk("rst2_tx_valid", {31'h0, tx_valid}, 32'h0);
      chk("rst2_prog_stop", {31'h0, prog_stop}, 32'h0);
      chk("rst2_rx_overflow", {31'h0, rx_overflow}, 32'h0);
      chk("rst2_cpu_din", {24'h0, cpu_din}, 32'h00);
      rst_in = 1'b0;
      tx_ready = 1'b1;
      tick();
      chk("rst2_no_partial_tx", {31'h0, tx_valid}, 32'h0);

      // Counter restarts at 0: after 255 cycles, read across the 0xFF->0x100 carry
      for (int c = 1; c < 255; c++) tick();
      for (int b = 0; b < 4; b++) begin
         cpu_a = 32'h30004 + b;
         tick();
         chk($sformatf("carry_byte%0d", b), {24'h0, cpu_din}, (b == 0) ? 32'hFF : 32'h00);
      end
      cpu_a = 32'h0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/io_bus_bridge.md
Name: io_bus_bridge

Overview:
- Sits directly downstream of the cpu core's byte memory bus (address, 8-bit write data, write strobe, 8-bit read data, io_buffer_full).
- Splits each access between the 128 KB RAM and the memory-mapped I/O region.
- Owns the UART TX/RX byte FIFOs, the cycle counter and the program-stop flag.
- Returns RAM and I/O read data with a uniform one-cycle latency, as the core expects.

Parameters:
- TX_DEPTH_LOG, 4, log2 of TX FIFO depth (16 entries).
- RX_DEPTH_LOG, 4, log2 of RX FIFO depth (16 entries).
- FULL_MARGIN, 2, free TX entries at or below which io_buffer_full asserts.

Ports:
- clk_in  input  1  system clock; only clock.
- rst_in  input  1  synchronous, active-high reset.
- rdy_in  input  1  cpu ready; low freezes all cpu-side state.
- cpu_a  input  32  cpu address; bits 17:0 used.
- cpu_dout  input  8  cpu write data.
- cpu_wr  input  1  1 = write, 0 = read.
- cpu_din  output  8  read data to cpu, valid the cycle after the address.
- io_buffer_full  output  1  TX FIFO near full.
- ram_a  output  17  RAM address.
- ram_dout  output  8  RAM write data.
- ram_we  output  1  RAM write enable.
- ram_din  input  8  RAM read data, one-cycle latency.
- rx_valid  input  1  UART RX byte strobe.
- rx_data  input  8  UART RX byte.
- tx_valid  output  1  TX FIFO non-empty.
- tx_data  output  8  TX FIFO head.
- tx_ready  input  1  UART TX accepts head.
- prog_stop  output  1  sticky; set on write to 0x30004.
- rx_overflow  output  1  sticky; an RX byte was dropped.

Behaviour:
- Decode: io = (cpu_a[17:16]==2'b11).
- RAM path (combinational):
  - ram_a = cpu_a[16:0]
  - ram_dout = cpu_dout
  - ram_we = cpu_wr & ~io & rdy_in
- Read select is registered. On rdy_in, sel_q <= {io & ~cpu_wr, cpu_a[2:0]}.
- cpu_din uses the previous cycle's sel_q:
  - RAM: ram_din.
  - Offset 0: the byte registered when the RX pop occurred; 0x00 if RX was empty.
  - Offsets 4..7: byte (offset-4) of cnt_snap, little-endian.
  - Other I/O offsets: 0x00.
- cpu_din holds its value while rdy_in is low.
- Cycle counter: 32-bit; increments every cycle rdy_in=1; wraps 0xFFFFFFFF to 0.
- cnt_snap: on a read of 0x30004, cnt_snap <= counter and byte 0 returns the counter value at the read cycle. Reads of 0x30005..7 use cnt_snap, so the word is coherent.
- I/O writes (rdy_in=1):
  - 0x30000 with data != 0: push to TX.
  - 0x30000 with data == 0: ignored.
  - 0x30004: set prog_stop and push 0x00 to TX.
  - If TX is full, the push is dropped silently; the core must honour io_buffer_full.
- io_buffer_full = (TX free entries <= FULL_MARGIN). It is combinational from the registered count.
- TX drain:
  - tx_valid = ~empty; tx_data = head.
  - Pop on tx_valid & tx_ready, independent of rdy_in.
  - Push and pop in the same cycle leaves the count unchanged.
- RX:
  - Push on rx_valid, regardless of rdy_in.
  - If full and there is no simultaneous pop, drop the byte and set rx_overflow.
  - Pop on a read of 0x30000 with rdy_in=1.
  - Simultaneous push/pop on a full FIFO is legal and drops nothing.
  - Pop when empty returns 0x00 and changes no pointers.
- FIFO pointers are TX_DEPTH_LOG+1 / RX_DEPTH_LOG+1 bits wide, with the MSB used for full/empty wrap. The storage index wraps naturally.
- rdy_in low: no cpu-side pushes or pops, counter frozen, sel_q held, ram_we=0. The UART sides keep running.
- Reset (clk_in edge with rst_in=1):
  - Both FIFOs empty; counter and cnt_snap = 0; sel_q = RAM.
  - cpu_din=0, tx_valid=0, prog_stop=0, rx_overflow=0, io_buffer_full=0.
  - Reset mid-transfer discards FIFO contents; no partial byte is emitted.

Test Plan:
- RAM: write 0xA5 to 0x00010 then read 0x00010 with ram model -> ram_we pulses once; cpu_din=0xA5 one cycle after the read address.
- TX: write 'H','i',0x00 to 0x30000, tx_ready=1 -> tx_data sequence 0x48, 0x69; the 0x00 write never appears.
- Backpressure: tx_ready=0, write 14 bytes -> io_buffer_full=1 after the 14th push. A 17th write is dropped; draining 16 emits the first 16 in order.
- Counter: hold rdy_in low for 5 of 20 cycles after reset, then read 0x30004..7 -> word = 15 (plus cycles spent reading, per snapshot rule). Bytes are coherent across a 0xFF->0x100 carry.
- RX: push 0x31, 0x32; read 0x30000 three times -> 0x31, 0x32, 0x00. Push 17 bytes without reads -> rx_overflow=1.
- Stop and reset: write any byte to 0x30004 -> prog_stop=1 and tx_data=0x00 queued. Assert rst_in with 3 bytes queued -> next cycle tx_valid=0, prog_stop=0, counter=0.
